// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_port peripheral: TX/RX state
// encodings, frame geometry and receive-FIFO depth.
package uart_pkg;

    localparam int UART_DATA_BITS     = 8;
    localparam int UART_FRAME_BITS    = 10;
    localparam int UART_RX_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_port_if.sv
// CPU-side UART strobe/status bundle. The master is the j1 I/O decode,
// the slave is uart_port.
interface uart_port_if;
    import uart_pkg::*;

    logic                      uart_wr;
    logic                      uart_rd;
    logic [UART_DATA_BITS-1:0] uart_w;
    logic                      uart_busy;
    logic                      uart_valid;
    logic [UART_DATA_BITS-1:0] uart_data;

    modport master (
        output uart_wr, uart_rd, uart_w,
        input  uart_busy, uart_valid, uart_data
    );

    modport slave (
        input  uart_wr, uart_rd, uart_w,
        output uart_busy, uart_valid, uart_data
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO (UART_RX_FIFO_DEPTH x 8). Pushes into a full FIFO are
// dropped; push and pop in the same cycle are both honoured. The head is
// presented as zero while empty so the data output has a defined value.
module uart_rx_fifo
    import uart_pkg::*;
(
    input  logic                      clk,
    input  logic                      resetq,
    input  logic                      push_i,
    input  logic [UART_DATA_BITS-1:0] din_i,
    input  logic                      pop_i,
    output logic [UART_DATA_BITS-1:0] dout_o,
    output logic                      empty_o
);
    localparam int PTR_W = $clog2(UART_RX_FIFO_DEPTH);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(UART_RX_FIFO_DEPTH);

    logic [UART_DATA_BITS-1:0] mem_q [UART_RX_FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q;
    logic [PTR_W-1:0]          rd_ptr_q;
    logic [PTR_W:0]            count_q;
    logic                      full;
    logic                      push_ok;
    logic                      pop_ok;

    assign full    = (count_q == COUNT_FULL);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full;
    assign pop_ok  = pop_i & ~empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage write; contents need no reset since the count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (depth is 2^n).
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_port.sv
// uart_port: 8N1 UART peripheral behind the j1 I/O bus. Independent TX and
// RX state machines, 2-flop rx synchronizer, and a receive holding register.
// Build option UART_RX_FIFO_EN replaces the holding register by a 4-entry
// FIFO (uart_rx_fifo).
module uart_port
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic        clk,
    input  logic        resetq,
    uart_port_if.slave  bus,
    input  logic        rx,
    output logic        tx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

    // ---------------- transmitter ----------------
    tx_state_e                 tx_state_q;
    logic [CNT_W-1:0]          tx_cnt_q;
    logic [IDX_W-1:0]          tx_idx_q;
    logic [UART_DATA_BITS-1:0] tx_shift_q;
    logic                      tx_q;
    logic                      busy_q;

    // TX FSM: start bit, 8 data bits LSB first, stop bit; tx and busy registered.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (bus.uart_wr) begin
                        tx_shift_q <= bus.uart_w;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == IDX_LAST) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= TX_STOP;
                        end else begin
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_idx_q   <= tx_idx_q + IDX_W'(1);
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        busy_q     <= 1'b0;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx            = tx_q;
    assign bus.uart_busy = busy_q;

    // ---------------- receiver ----------------
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    rx_state_e                 rx_state_q;
    logic [CNT_W-1:0]          rx_cnt_q;
    logic [IDX_W-1:0]          rx_idx_q;
    logic [UART_DATA_BITS-1:0] rx_shift_q;
    logic                      rx_done_q;

    // RX FSM: half-bit start check, 8 centre samples, stop-bit validation.
    // rx_done_q pulses for one cycle when a well-framed byte is in rx_shift_q.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_done_q <= 1'b0;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q <= '0;
                        rx_idx_q <= '0;
                        rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_sync_q, rx_shift_q[UART_DATA_BITS-1:1]};
                        if (rx_idx_q == IDX_LAST) begin
                            rx_state_q <= RX_STOP;
                        end else begin
                            rx_idx_q <= rx_idx_q + IDX_W'(1);
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_done_q  <= rx_sync_q;
                        rx_state_q <= RX_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

`ifdef UART_RX_FIFO_EN
    logic fifo_empty;

    uart_rx_fifo u_rx_fifo (
        .clk     (clk),
        .resetq  (resetq),
        .push_i  (rx_done_q),
        .din_i   (rx_shift_q),
        .pop_i   (bus.uart_rd),
        .dout_o  (bus.uart_data),
        .empty_o (fifo_empty)
    );

    assign bus.uart_valid = ~fifo_empty;
`else
    logic                      valid_q;
    logic [UART_DATA_BITS-1:0] data_q;

    // Holding register: a new byte wins over a same-cycle read and overwrites unread data.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (rx_done_q) begin
            valid_q <= 1'b1;
            data_q  <= rx_shift_q;
        end else if (bus.uart_rd) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.uart_valid = valid_q;
    assign bus.uart_data  = data_q;
`endif

endmodule
